rids_bitonic_feeder: RTL and testbench
======================================

# rids_bitonic_feeder

Front end of the bitonic merging tree: it accepts rule ID sets (RIDS) from two independent field-lookup streams and buffers each stream in its own FIFO. It pairs the k-th set of stream A with the k-th set of stream B and emits the pair as one bitonic 2×RIDS word: A kept ascending, B reversed to descending. The output is the exact input format the merge PE requires. It sits between the field lookup engines and the first merge PE of the tree.

## Interface
Parameters:
- RID_W, 4, width of one rule ID; value 0 means invalid or empty.
- NUM_RULE_ID, 8, rule IDs per set.
- RIDS_WIDTH, RID_W*NUM_RULE_ID (32), width of one set.
- FIFO_DEPTH, 4, entries per input FIFO; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock, rising-edge.
- reset_n  in  1  reset, asynchronous, active-low.
- a_valid  in  1  stream A set valid.
- a_ready  out  1  stream A FIFO can accept.
- a_rids  in  [0:RIDS_WIDTH-1]  stream A set; entry i at [i*RID_W +: RID_W], nondecreasing.
- b_valid / b_ready / b_rids: same as stream A, for stream B.
- out_valid  out  1  paired bitonic word valid.
- out_ready  in  1  downstream accepts; tie to 1 for a free-running PE.
- out_rids  out  [0:2*RIDS_WIDTH-1]  paired word.
- pair_cnt  out  16  number of pairs accepted downstream, wraps.
- err_order  out  1  sticky order-violation flag (see Configuration).

## Operation
- Each stream has an independent FIFO with read pointer, write pointer, and count. Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- a_ready = (countA != FIFO_DEPTH), registered-count based, with no combinational path from out_ready. B is identical.
- Push A on a_valid && a_ready. Push B the same way.
- pop = !emptyA && !emptyB && (!out_valid || out_ready). Both FIFOs pop together; a pair is never split.
- On pop, out_rids is loaded with {A[0..N-1], B[N-1..0]}:
  - entry j = A[j] for j < N;
  - entry N+j = B[N-1-j].
- Pairing is strictly in arrival order per stream. There are no tags.
- Output register hold: while out_valid && !out_ready, out_rids and out_valid are frozen.
- pair_cnt increments on out_valid && out_ready and wraps from 0xFFFF to 0.
- Simultaneous push and pop on the same FIFO: the count is unchanged and both operations take effect.
- A full FIFO has no write-through: a_ready is 0, the input is held by the source, and nothing is dropped.
- One stream empty: the other stream buffers up to FIFO_DEPTH sets, then backpressures.
- Reset asserted mid-operation: FIFO contents are discarded and all state returns to reset values immediately, asynchronously.

## Timing
- Reset values: a_ready=0 and b_ready=0 while reset_n=0, then 1 from the first cycle after release. out_valid=0, out_rids=0, pair_cnt=0, err_order=0.
- Latency: the later of the two matching sets is accepted at edge t; out_valid=1 after edge t+1.
- Throughput: one pair per cycle when both FIFOs are non-empty and out_ready=1.
- A read of a FIFO in the same cycle it is written from empty is not allowed; the entry becomes visible one cycle later.

## Configuration
- FEEDER_ORDER_CHECK_EN defined: every accepted set on either stream is checked for entry[i] ≤ entry[i+1] for all i.
  - On violation, err_order is set at the next edge and stays set until reset.
  - The set is still forwarded unchanged.
- Undefined: no checker logic is built and err_order is constant 0.

## Test plan
- A=0x00001357 then B=0x00023457 (one cycle apart), out_ready=1 -> out_rids=0x00001357_75432000, out_valid for exactly one cycle, pair_cnt=1.
- Push 4 sets on A with no B -> a_ready=0 after the 4th push and out_valid stays 0. Then push 4 B sets -> 4 pairs emitted in A/B arrival order, back-to-back.
- Both streams streaming with out_ready held at 0 for 5 cycles -> out_rids is stable, both FIFOs fill, and both readies drop. On release, all pairs are delivered with no loss or duplication.
- Drive reset_n low for 1 cycle with 3 entries queued -> out_valid=0 and pair_cnt=0 immediately. No stale pair appears after release.
- With FEEDER_ORDER_CHECK_EN, A=0x00005300 -> err_order=1 and stays 1; the pair is still emitted. Without the macro, err_order=0.
- 65536 pairs -> pair_cnt wraps to 0.

Source files
------------

// File: rtl/rids_bitonic_feeder.sv
// Pairs rule-ID sets from two lookup streams into one bitonic word (A ascending, B reversed).
// Optional order checker enabled by defining FEEDER_ORDER_CHECK_EN.
module rids_bitonic_feeder #(
  parameter int RID_W       = 4,
  parameter int NUM_RULE_ID = 8,
  parameter int RIDS_WIDTH  = RID_W * NUM_RULE_ID,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [0:RIDS_WIDTH-1]     a_rids,
  input  logic                      b_valid,
  output logic                      b_ready,
  input  logic [0:RIDS_WIDTH-1]     b_rids,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [0:2*RIDS_WIDTH-1]   out_rids,
  output logic [15:0]               pair_cnt,
  output logic                      err_order
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [0:RIDS_WIDTH-1] rids_t;

  logic                    r_live;
  logic                    r_out_valid;
  logic [0:2*RIDS_WIDTH-1] r_out_rids;
  logic [15:0]             r_pair_cnt;

  logic [1:0]              w_ready;
  logic [1:0]              w_empty;
  logic [1:0]              w_push;
  logic                    w_pop;
  rids_t                   w_in   [2];
  rids_t                   w_head [2];
  logic [0:2*RIDS_WIDTH-1] w_pair;

  assign w_in[0] = a_rids;
  assign w_in[1] = b_rids;
  assign w_push  = {b_valid, a_valid} & w_ready;
  assign w_pop   = !w_empty[0] && !w_empty[1] && (!r_out_valid || out_ready);

  assign a_ready = w_ready[0];
  assign b_ready = w_ready[1];

  // Readies stay low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) r_live <= 1'b0;
    else          r_live <= 1'b1;
  end

  for (genvar s = 0; s < 2; s++) begin : g_fifo
    rids_t            r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    assign w_ready[s] = r_live && (r_count != CNT_W'(FIFO_DEPTH));
    assign w_empty[s] = (r_count == '0);
    assign w_head[s]  = r_mem[r_rd_ptr];

    // NOTE: storage has no reset; resetting the pointers and count is what discards contents.
    always_ff @(posedge clk) begin
      if (w_push[s]) r_mem[r_wr_ptr] <= w_in[s];
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push[s]) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push[s], w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_comb begin
    // NOTE: the default assignment first keeps this block free of inferred latches.
    w_pair = '0;
    for (int j = 0; j < NUM_RULE_ID; j++) begin
      w_pair[j*RID_W +: RID_W]               = w_head[0][j*RID_W +: RID_W];
      w_pair[(NUM_RULE_ID+j)*RID_W +: RID_W] = w_head[1][(NUM_RULE_ID-1-j)*RID_W +: RID_W];
    end
  end

  // Output register: loads on pop, clears when drained, frozen under backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_rids  <= '0;
      r_pair_cnt  <= '0;
    end else begin
      if (w_pop) begin
        r_out_valid <= 1'b1;
        r_out_rids  <= w_pair;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (r_out_valid && out_ready) r_pair_cnt <= r_pair_cnt + 16'd1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_rids  = r_out_rids;
  assign pair_cnt  = r_pair_cnt;

`ifdef FEEDER_ORDER_CHECK_EN
  function automatic logic order_bad(input rids_t set);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_RULE_ID - 1; i++) begin
      if (set[i*RID_W +: RID_W] > set[(i+1)*RID_W +: RID_W]) bad = 1'b1;
    end
    return bad;
  endfunction

  logic r_err_order;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_err_order <= 1'b0;
    else if ((w_push[0] && order_bad(a_rids)) || (w_push[1] && order_bad(b_rids)))
      r_err_order <= 1'b1;
  end

  assign err_order = r_err_order;
`else
  assign err_order = 1'b0;
`endif

endmodule

// File: tb/tb_rids_bitonic_feeder.sv
// Randomized self-checking bench for rids_bitonic_feeder against a queue-based pairing model.
module tb_rids_bitonic_feeder;
  localparam int W = 4;
  localparam int N = 8;

`ifdef FEEDER_ORDER_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b1;
  logic [0:31] a_rids = '0, b_rids = '0;
  logic        a_ready, b_ready, out_valid, err_order;
  logic [0:63] out_rids;
  logic [15:0] pair_cnt;

  rids_bitonic_feeder #(.RID_W(W), .NUM_RULE_ID(N), .RIDS_WIDTH(W*N), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_rids(a_rids),
    .b_valid(b_valid), .b_ready(b_ready), .b_rids(b_rids),
    .out_valid(out_valid), .out_ready(out_ready), .out_rids(out_rids),
    .pair_cnt(pair_cnt), .err_order(err_order)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [15:0] model_cnt = '0;
  logic        hold_pending = 1'b0;
  logic [63:0] held;
  logic        a_took = 1'b0, b_took = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Random nondecreasing set, entry 0 in the most significant nibble.
  function automatic logic [31:0] rand_set();
    logic [31:0] v;
    int e;
    v = '0;
    e = 0;
    for (int i = 0; i < N; i++) begin
      e = e + int'($urandom_range(0, 2));
      if (e > 15) e = 15;
      v = (v << 4) | 32'(e);
    end
    return v;
  endfunction

  // Expected word: A unchanged in the upper half, B nibble-reversed in the lower half.
  function automatic logic [63:0] make_pair(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {a, 32'h0};
    for (int j = 0; j < N; j++)
      p = p | (64'((b >> (4*j)) & 32'hF) << (4*(N-1-j)));
    return p;
  endfunction

  task automatic monitor();
    if (hold_pending) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data", out_rids, held);
      hold_pending = 1'b0;
    end
    if (out_valid && out_ready) begin
      check("pair_avail", 64'(qa.size() > 0 && qb.size() > 0), 64'd1);
      if (qa.size() > 0 && qb.size() > 0)
        check("pair_data", out_rids, make_pair(qa.pop_front(), qb.pop_front()));
      check("pair_cnt", 64'(pair_cnt), 64'(model_cnt));
      model_cnt = model_cnt + 16'd1;
    end else if (out_valid) begin
      held = out_rids;
      hold_pending = 1'b1;
    end
    a_took = a_valid && a_ready;
    b_took = b_valid && b_ready;
    if (a_took) qa.push_back(a_rids);
    if (b_took) qb.push_back(b_rids);
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_drive(input int pa, input int pb);
    if (!a_valid || a_took) begin
      a_valid = ($urandom_range(0, 99) < pa);
      a_rids  = rand_set();
    end
    if (!b_valid || b_took) begin
      b_valid = ($urandom_range(0, 99) < pb);
      b_rids  = rand_set();
    end
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (!out_valid && (qa.size() == 0 || qb.size() == 0)) done = 1'b1;
    end
    check(tag, 64'(done), 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_high, first, last;
    bit wrapped;

    repeat (3) @(posedge clk);
    #1;
    check("rst_a_ready", 64'(a_ready), 64'd0);
    check("rst_b_ready", 64'(b_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_rids", out_rids, 64'd0);
    check("rst_pair_cnt", 64'(pair_cnt), 64'd0);
    check("rst_err", 64'(err_order), 64'd0);
    reset_n = 1'b1;
    check("rel_a_ready_pre", 64'(a_ready), 64'd0);
    step();
    check("rel_a_ready", 64'(a_ready), 64'd1);
    check("rel_b_ready", 64'(b_ready), 64'd1);

    // Directed vector: A then B one cycle apart.
    a_rids = 32'h00001357; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    b_rids = 32'h00023457; b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    check("lat_not_early", 64'(out_valid), 64'd0);
    step();
    check("vec_valid", 64'(out_valid), 64'd1);
    check("vec_data", out_rids, 64'h00001357_75432000);
    step();
    check("vec_one_cycle", 64'(out_valid), 64'd0);
    check("vec_cnt", 64'(pair_cnt), 64'd1);

    // Fill A alone, then supply B.
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_rids = rand_set();
      step();
    end
    a_valid = 1'b0;
    check("afull_ready", 64'(a_ready), 64'd0);
    check("afull_noout", 64'(out_valid), 64'd0);
    step();
    check("afull_noout2", 64'(out_valid), 64'd0);
    n_high = 0; first = -1; last = -1;
    for (int i = 0; i < 12; i++) begin
      if (i < 4) begin b_valid = 1'b1; b_rids = rand_set(); end
      else b_valid = 1'b0;
      step();
      if (out_valid) begin
        n_high++;
        if (first < 0) first = i;
        last = i;
      end
    end
    check("b2b_count", 64'(n_high), 64'd4);
    check("b2b_contig", 64'(last - first + 1), 64'd4);
    check("afull_ready_back", 64'(a_ready), 64'd1);

    // Backpressure with both streams saturating.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_drive(100, 100);
      step();
    end
    check("bp_a_ready", 64'(a_ready), 64'd0);
    check("bp_b_ready", 64'(b_ready), 64'd0);
    check("bp_valid", 64'(out_valid), 64'd1);
    drain("bp_drain");
    check("bp_no_loss", 64'(qa.size() + qb.size()), 64'd0);

    // Random traffic with random downstream stalls.
    a_took = 1'b0; b_took = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rand_drive(70, 70);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain("rand_drain");

    // Reset with entries queued.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_drive(100, 100);
      step();
    end
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_cnt", 64'(pair_cnt), 64'd0);
    check("mid_rst_ready", 64'(a_ready), 64'd0);
    qa.delete(); qb.delete();
    model_cnt = '0; hold_pending = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_took = 1'b0; b_took = 1'b0;
    out_ready = 1'b1;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("no_stale", 64'(out_valid), 64'd0);
    end

    // Out-of-order set on A.
    a_rids = 32'h00005300; a_valid = 1'b1;
    b_rids = rand_set();   b_valid = 1'b1;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    check("err_set", 64'(err_order), 64'(EXP_ERR));
    repeat (3) step();
    check("err_sticky", 64'(err_order), 64'(EXP_ERR));
    check("err_pair_sent", 64'(model_cnt), 64'd1);

    // Run pair_cnt through its wrap.
    wrapped = 1'b0;
    a_took = 1'b0; b_took = 1'b0;
    for (int i = 0; i < 70000 && !wrapped; i++) begin
      rand_drive(100, 100);
      step();
      if (model_cnt == 16'h0000) wrapped = 1'b1;
    end
    check("wrap_reached", 64'(wrapped), 64'd1);
    check("wrap_cnt", 64'(pair_cnt), 64'd0);
    drain("wrap_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
